// File: rtl/regfile_wb_ctrl.sv
// Writeback controller for the 32x32 register file: tracks pending destinations,
// buffers ALU/load completions in a small FIFO and drains one write per cycle.
module regfile_wb_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic        iss_ready,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic        hazard,
  input  logic        c0_valid,
  input  logic [4:0]  c0_rd,
  input  logic [31:0] c0_data,
  output logic        c0_ready,
  input  logic        c1_valid,
  input  logic [4:0]  c1_rd,
  input  logic [31:0] c1_data,
  output logic        c1_ready,
  output logic        we3,
  output logic [4:0]  wa3,
  output logic [31:0] wd3,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] L_ONE   = (AW+1)'(1);
  localparam logic [AW:0] L_TWO   = (AW+1)'(2);

  logic [31:0] r_pending;
  logic [4:0]  r_fifo_rd   [DEPTH];
  logic [31:0] r_fifo_data [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        r_we3;
  logic [4:0]  r_wa3;
  logic [31:0] r_wd3;
  logic        r_err;

  logic [AW:0] w_count;
  logic [AW:0] w_free;
  logic        w_empty;
  logic        w_c0_push;
  logic        w_c1_push;
  logic [AW:0] w_wptr_c1;
  logic [AW:0] w_wptr_nxt;
  logic        w_iss_set;
  logic        w_err_set;
  logic [31:0] w_pending_nxt;

  // Ready depends only on registered occupancy; a same-cycle pop does not free a slot.
  assign w_count = r_wptr - r_rptr;
  assign w_free  = L_DEPTH - w_count;
  assign w_empty = (r_wptr == r_rptr);

  assign c0_ready = (w_free >= L_ONE);
  assign c1_ready = c0_valid ? (w_free >= L_TWO) : (w_free >= L_ONE);

  assign w_c0_push  = c0_valid && c0_ready && (c0_rd != 5'd0);
  assign w_c1_push  = c1_valid && c1_ready && (c1_rd != 5'd0);
  assign w_wptr_c1  = w_c0_push ? (r_wptr + L_ONE) : r_wptr;
  assign w_wptr_nxt = w_c1_push ? (w_wptr_c1 + L_ONE) : w_wptr_c1;

  assign w_err_set = (w_c0_push && !r_pending[c0_rd]) || (w_c1_push && !r_pending[c1_rd]);

  assign iss_ready = !((iss_rd != 5'd0) && r_pending[iss_rd]);
  assign w_iss_set = iss_valid && iss_ready && (iss_rd != 5'd0);
  assign hazard    = r_pending[ra1] | r_pending[ra2];

  // NOTE: every variable gets its default before any conditional update, so no latch is inferred.
  always_comb begin
    w_pending_nxt = r_pending;
    if (r_we3)     w_pending_nxt[r_wa3]  = 1'b0;
    if (w_iss_set) w_pending_nxt[iss_rd] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_we3     <= 1'b0;
      r_wa3     <= '0;
      r_wd3     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      r_wptr    <= w_wptr_nxt;
      r_err     <= r_err | w_err_set;
      if (!w_empty) begin
        r_rptr <= r_rptr + L_ONE;
        r_we3  <= 1'b1;
        r_wa3  <= r_fifo_rd[r_rptr[AW-1:0]];
        r_wd3  <= r_fifo_data[r_rptr[AW-1:0]];
      end else begin
        r_we3 <= 1'b0;
      end
    end
  end

  // NOTE: FIFO storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_c0_push) begin
      r_fifo_rd[r_wptr[AW-1:0]]   <= c0_rd;
      r_fifo_data[r_wptr[AW-1:0]] <= c0_data;
    end
    if (w_c1_push) begin
      r_fifo_rd[w_wptr_c1[AW-1:0]]   <= c1_rd;
      r_fifo_data[w_wptr_c1[AW-1:0]] <= c1_data;
    end
  end

  assign we3 = r_we3;
  assign wa3 = r_wa3;
  assign wd3 = r_wd3;
  assign err = r_err;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Scoreboard bench for regfile_wb_ctrl: accepted completions queue expected writes,
// a monitor pops and compares each we3 pulse; directed scenarios check control outputs.
module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [4:0]  ra1, ra2;
  logic        hazard;
  logic        c0_valid, c1_valid;
  logic [4:0]  c0_rd, c1_rd;
  logic [31:0] c0_data, c1_data;
  logic        c0_ready, c1_ready;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic        err;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_tests = 0;
  int  n_fail  = 0;

  regfile_wb_ctrl #(.DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .ra1(ra1), .ra2(ra2), .hazard(hazard),
    .c0_valid(c0_valid), .c0_rd(c0_rd), .c0_data(c0_data), .c0_ready(c0_ready),
    .c1_valid(c1_valid), .c1_rd(c1_rd), .c1_data(c1_data), .c1_ready(c1_ready),
    .we3(we3), .wa3(wa3), .wd3(wd3), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the oldest accepted, non-x0 completion.
  always @(negedge clk) begin
    if (reset_n && we3) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got wa3=%0d wd3=0x%0h expected no write", wa3, wd3);
      end else begin
        mon_e = exp_q.pop_front();
        check("mon_wa3", 32'(wa3), 32'(mon_e.rd));
        check("mon_wd3", wd3, mon_e.data);
      end
    end
  end

  task automatic clr();
    iss_valid = 1'b0; iss_rd = '0;
    c0_valid = 1'b0; c0_rd = '0; c0_data = '0;
    c1_valid = 1'b0; c1_rd = '0; c1_data = '0;
  endtask

  // Called at posedge+1; returns at posedge+4 after recording completions that will transfer.
  task automatic settle();
    #3;
    if (c0_valid && c0_ready && c0_rd != 5'd0) exp_q.push_back('{rd: c0_rd, data: c0_data});
    if (c1_valid && c1_ready && c1_rd != 5'd0) exp_q.push_back('{rd: c1_rd, data: c1_data});
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    clr();
    repeat (n) begin
      settle();
      adv();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int    nxt;
    bit    exp_c1r [6];
    reset_n = 1'b0;
    clr();
    ra1 = '0; ra2 = '0;

    // Reset held with random inputs
    exp_c1r = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    repeat (3) begin
      @(posedge clk); #1;
      iss_valid = 1'($urandom); iss_rd = 5'($urandom);
      c0_valid = 1'($urandom); c0_rd = 5'($urandom); c0_data = $urandom;
      c1_valid = 1'($urandom); c1_rd = 5'($urandom); c1_data = $urandom;
      ra1 = 5'($urandom); ra2 = 5'($urandom);
      #3;
      check("rst_we3", 32'(we3), 0);
      check("rst_hazard", 32'(hazard), 0);
      check("rst_iss_ready", 32'(iss_ready), 1);
      check("rst_err", 32'(err), 0);
      check("rst_c0_ready", 32'(c0_ready), 1);
      check("rst_c1_ready", 32'(c1_ready), 1);
    end
    @(posedge clk); #1;
    clr(); ra1 = '0; ra2 = '0;
    reset_n = 1'b1;
    idle(3);

    // Single op: issue rd=5, complete, observe write latency and hazard clear
    iss_valid = 1'b1; iss_rd = 5'd5; ra1 = 5'd5;
    settle();
    check("single_iss_ready", 32'(iss_ready), 1);
    check("single_hazard_pre", 32'(hazard), 0);
    adv();
    iss_valid = 1'b0;
    c0_valid = 1'b1; c0_rd = 5'd5; c0_data = 32'hDEADBEEF;
    settle();
    check("single_hazard_set", 32'(hazard), 1);
    check("single_c0_ready", 32'(c0_ready), 1);
    adv();
    clr();
    settle();
    check("single_we3_T1", 32'(we3), 0);
    check("single_hazard_T1", 32'(hazard), 1);
    adv();
    settle();
    check("single_we3_T2", 32'(we3), 1);
    check("single_wa3", 32'(wa3), 5);
    check("single_wd3", wd3, 32'hDEADBEEF);
    check("single_hazard_T2", 32'(hazard), 1);
    adv();
    settle();
    check("single_hazard_clr", 32'(hazard), 0);
    check("single_we3_off", 32'(we3), 0);
    adv();

    // WAW stall on rd=7
    ra1 = 5'd7;
    iss_valid = 1'b1; iss_rd = 5'd7;
    settle();
    check("waw_first_ready", 32'(iss_ready), 1);
    adv();
    c0_valid = 1'b1; c0_rd = 5'd7; c0_data = 32'h77;
    settle();
    check("waw_stall0", 32'(iss_ready), 0);
    check("waw_hazard", 32'(hazard), 1);
    adv();
    c0_valid = 1'b0;
    settle();
    check("waw_stall1", 32'(iss_ready), 0);
    adv();
    settle();
    check("waw_write_we3", 32'(we3), 1);
    check("waw_stall2", 32'(iss_ready), 0);
    adv();
    settle();
    check("waw_accept", 32'(iss_ready), 1);
    adv();
    iss_valid = 1'b0;
    c0_valid = 1'b1; c0_rd = 5'd7; c0_data = 32'h78;
    settle();
    check("waw_repending", 32'(hazard), 1);
    adv();
    idle(4);
    settle();
    check("waw_hazard_clr", 32'(hazard), 0);
    adv();

    // Dual completion ordering
    ra1 = 5'd1; ra2 = 5'd2;
    iss_valid = 1'b1; iss_rd = 5'd1;
    settle(); adv();
    iss_rd = 5'd2;
    settle();
    check("dual_iss_ready", 32'(iss_ready), 1);
    adv();
    iss_valid = 1'b0;
    c0_valid = 1'b1; c0_rd = 5'd1; c0_data = 32'h11;
    c1_valid = 1'b1; c1_rd = 5'd2; c1_data = 32'h22;
    settle();
    check("dual_c0_ready", 32'(c0_ready), 1);
    check("dual_c1_ready", 32'(c1_ready), 1);
    check("dual_hazard", 32'(hazard), 1);
    adv();
    clr();
    settle(); adv();
    settle();
    check("dual_first_wa3", 32'(wa3), 1);
    check("dual_first_wd3", wd3, 32'h11);
    adv();
    settle();
    check("dual_second_wa3", 32'(wa3), 2);
    check("dual_second_wd3", wd3, 32'h22);
    adv();
    idle(2);
    settle();
    check("dual_hazard_clr", 32'(hazard), 0);
    adv();

    // Backpressure: issue rd 1..8, then offer two completions per cycle
    for (int i = 1; i <= 8; i++) begin
      iss_valid = 1'b1; iss_rd = 5'(i);
      settle();
      check("bp_iss_ready", 32'(iss_ready), 1);
      adv();
    end
    clr();
    nxt = 1;
    for (int c = 0; c < 6; c++) begin
      c0_valid = (nxt <= 8);     c0_rd = 5'(nxt);     c0_data = 32'h100 + 32'(nxt);
      c1_valid = (nxt + 1 <= 8); c1_rd = 5'(nxt + 1); c1_data = 32'h100 + 32'(nxt + 1);
      settle();
      check("bp_c0_ready", 32'(c0_ready), 1);
      check("bp_c1_ready", 32'(c1_ready), 32'(exp_c1r[c]));
      nxt += int'(c0_valid && c0_ready) + int'(c1_valid && c1_ready);
      adv();
    end
    check("bp_accepted", nxt, 9);
    idle(6);
    check("bp_drained", exp_q.size(), 0);
    ra1 = 5'd8; ra2 = 5'd3;
    settle();
    check("bp_hazard_clr", 32'(hazard), 0);
    adv();

    // x0 issue and completion, then error on unissued rd=9
    iss_valid = 1'b1; iss_rd = 5'd0;
    settle();
    check("x0_iss_ready", 32'(iss_ready), 1);
    adv();
    clr();
    ra1 = 5'd0; ra2 = 5'd0;
    c0_valid = 1'b1; c0_rd = 5'd0; c0_data = 32'hBAD;
    settle();
    check("x0_hazard", 32'(hazard), 0);
    check("x0_c0_ready", 32'(c0_ready), 1);
    adv();
    idle(3);
    check("x0_no_err", 32'(err), 0);
    c0_valid = 1'b1; c0_rd = 5'd9; c0_data = 32'h99;
    settle(); adv();
    clr();
    settle();
    check("err_set", 32'(err), 1);
    adv();
    idle(3);
    check("err_sticky", 32'(err), 1);

    // Reset mid-operation: pending bit and buffered completion dropped
    iss_valid = 1'b1; iss_rd = 5'd12;
    settle(); adv();
    clr();
    c0_valid = 1'b1; c0_rd = 5'd10; c0_data = 32'hAA;
    settle(); adv();
    clr();
    reset_n = 1'b0;
    exp_q.delete();
    ra1 = 5'd12;
    #3;
    check("midrst_we3", 32'(we3), 0);
    check("midrst_err", 32'(err), 0);
    adv(); adv();
    reset_n = 1'b1;
    idle(3);
    settle();
    check("midrst_hazard", 32'(hazard), 0);
    check("midrst_iss_ready", 32'(iss_ready), 1);
    adv();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
